bmc_subframe_decoder: RTL

BMC_SUBFRAME_DECODER -- requirements
Module: bmc_subframe_decoder

---
 rtl/bmc_subframe_decoder.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/bmc_subframe_decoder.sv
// Biphase-mark subframe decoder: hunts for B/M/W preambles, decodes 28 data cells,
// checks cell transitions and even parity, and presents audio words on a valid/ready port.
module bmc_subframe_decoder #(
    parameter int AUDIO_BITS       = 24,
    parameter int FRAMES_PER_BLOCK = 192,
    parameter bit PARITY_CHECK     = 1'b1,
    localparam int FC_W            = $clog2(FRAMES_PER_BLOCK)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  vin,
    input  logic                  din,
    output logic [AUDIO_BITS-1:0] sample_data,
    output logic                  sample_valid,
    input  logic                  sample_ready,
    output logic                  sample_channel,
    output logic [2:0]            sample_vuc,
    output logic [FC_W-1:0]       frame_counter,
    output logic                  block_start,
    output logic                  locked,
    output logic                  bmc_err,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  overflow
);

    typedef enum logic [0:0] {ST_HUNT = 1'b0, ST_DATA = 1'b1} state_t;

    localparam logic [7:0]      PRE_B   = 8'b11101000;
    localparam logic [7:0]      PRE_M   = 8'b11100010;
    localparam logic [7:0]      PRE_W   = 8'b11100100;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAMES_PER_BLOCK - 1);

    function automatic logic parity_odd(input logic [27:0] w);
        return ^w;
    endfunction

    // A preamble may arrive in either polarity depending on the preceding line level.
    function automatic logic is_pre(input logic [7:0] sr, input logic [7:0] pat);
        return (sr == pat) || (sr == ~pat);
    endfunction

    state_t                state_r, state_n;
    logic [7:0]            sr_r, sr_n, sr_s;
    logic [3:0]            fill_r, fill_n, fill_s;
    logic [5:0]            hc_cnt_r, hc_cnt_n;
    logic                  prev_hc_r, prev_hc_n;
    logic [26:0]           word_r, word_n;
    logic                  locked_r, locked_n;
    logic [FC_W-1:0]       fc_r, fc_n;
    logic                  chan_r, chan_n;
    logic                  blk_r, blk_n;
    logic [AUDIO_BITS-1:0] data_r, data_n;
    logic                  valid_r, valid_n;
    logic                  ch_out_r, ch_out_n;
    logic [2:0]            vuc_r, vuc_n;
    logic                  bs_r, bs_n;
    logic                  bmc_err_r, bmc_err_n;
    logic                  parity_err_r, parity_err_n;
    logic                  frame_err_r, frame_err_n;
    logic                  overflow_r, overflow_n;
    logic                  bit_s;
    logic [27:0]           full_s;

    // Next-state computation for the hunt/data FSM, decoded word and output register.
    always_comb begin
        state_n      = state_r;
        sr_n         = sr_r;
        fill_n       = fill_r;
        hc_cnt_n     = hc_cnt_r;
        prev_hc_n    = prev_hc_r;
        word_n       = word_r;
        locked_n     = locked_r;
        fc_n         = fc_r;
        chan_n       = chan_r;
        blk_n        = blk_r;
        data_n       = data_r;
        ch_out_n     = ch_out_r;
        vuc_n        = vuc_r;
        bs_n         = bs_r;
        bmc_err_n    = 1'b0;
        parity_err_n = 1'b0;
        frame_err_n  = 1'b0;
        overflow_n   = 1'b0;
        sr_s         = {sr_r[6:0], din};
        fill_s       = (fill_r == 4'd8) ? 4'd8 : fill_r + 4'd1;
        bit_s        = din ^ prev_hc_r;
        full_s       = {bit_s, word_r};

        if (valid_r && sample_ready) begin
            valid_n = 1'b0;
        end else begin
            valid_n = valid_r;
        end

        if (vin) begin
            case (state_r)
                ST_HUNT: begin
                    sr_n      = sr_s;
                    fill_n    = fill_s;
                    prev_hc_n = din;
                    hc_cnt_n  = 6'd0;
                    if (fill_s != 4'd8) begin
                        state_n = ST_HUNT;
                    end else if (is_pre(sr_s, PRE_B)) begin
                        state_n  = ST_DATA;
                        locked_n = 1'b1;
                        fc_n     = '0;
                        chan_n   = 1'b0;
                        blk_n    = 1'b1;
                    end else if (locked_r && is_pre(sr_s, PRE_M)) begin
                        if (fc_r == FC_LAST) begin
                            frame_err_n = 1'b1;
                            locked_n    = 1'b0;
                        end else begin
                            state_n = ST_DATA;
                            fc_n    = fc_r + FC_W'(1);
                            chan_n  = 1'b0;
                            blk_n   = 1'b0;
                        end
                    end else if (locked_r && is_pre(sr_s, PRE_W)) begin
                        state_n = ST_DATA;
                        chan_n  = 1'b1;
                        blk_n   = 1'b0;
                    end else begin
                        state_n = ST_HUNT;
                    end
                end
                ST_DATA: begin
                    prev_hc_n = din;
                    hc_cnt_n  = hc_cnt_r + 6'd1;
                    if (!hc_cnt_r[0]) begin
                        // Every cell must open with a level change.
                        if (din == prev_hc_r) begin
                            bmc_err_n = 1'b1;
                            locked_n  = 1'b0;
                            state_n   = ST_HUNT;
                            fill_n    = 4'd0;
                        end else begin
                            state_n = ST_DATA;
                        end
                    end else if (hc_cnt_r == 6'd55) begin
                        state_n = ST_HUNT;
                        fill_n  = 4'd0;
                        if (PARITY_CHECK && parity_odd(full_s)) begin
                            parity_err_n = 1'b1;
                        end else if (valid_r && !sample_ready) begin
                            overflow_n = 1'b1;
                        end else begin
                            valid_n  = 1'b1;
                            data_n   = full_s[23 -: AUDIO_BITS];
                            vuc_n    = {full_s[24], full_s[25], full_s[26]};
                            ch_out_n = chan_r;
                            bs_n     = blk_r;
                        end
                    end else begin
                        word_n[hc_cnt_r[5:1]] = bit_s;
                    end
                end
                default: begin
                    state_n = ST_HUNT;
                    fill_n  = 4'd0;
                end
            endcase
        end else begin
            state_n = state_r;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_HUNT;
            sr_r         <= 8'd0;
            fill_r       <= 4'd0;
            hc_cnt_r     <= 6'd0;
            prev_hc_r    <= 1'b0;
            word_r       <= 27'd0;
            locked_r     <= 1'b0;
            fc_r         <= '0;
            chan_r       <= 1'b0;
            blk_r        <= 1'b0;
            data_r       <= '0;
            valid_r      <= 1'b0;
            ch_out_r     <= 1'b0;
            vuc_r        <= 3'd0;
            bs_r         <= 1'b0;
            bmc_err_r    <= 1'b0;
            parity_err_r <= 1'b0;
            frame_err_r  <= 1'b0;
            overflow_r   <= 1'b0;
        end else begin
            state_r      <= state_n;
            sr_r         <= sr_n;
            fill_r       <= fill_n;
            hc_cnt_r     <= hc_cnt_n;
            prev_hc_r    <= prev_hc_n;
            word_r       <= word_n;
            locked_r     <= locked_n;
            fc_r         <= fc_n;
            chan_r       <= chan_n;
            blk_r        <= blk_n;
            data_r       <= data_n;
            valid_r      <= valid_n;
            ch_out_r     <= ch_out_n;
            vuc_r        <= vuc_n;
            bs_r         <= bs_n;
            bmc_err_r    <= bmc_err_n;
            parity_err_r <= parity_err_n;
            frame_err_r  <= frame_err_n;
            overflow_r   <= overflow_n;
        end
    end

    assign sample_data    = data_r;
    assign sample_valid   = valid_r;
    assign sample_channel = ch_out_r;
    assign sample_vuc     = vuc_r;
    assign frame_counter  = fc_r;
    assign block_start    = bs_r;
    assign locked         = locked_r;
    assign bmc_err        = bmc_err_r;
    assign parity_err     = parity_err_r;
    assign frame_err      = frame_err_r;
    assign overflow       = overflow_r;

endmodule
